// File: rtl/axi_sram_slave_if.sv
// AXI3 write/read channel bundle between the cache bridge (master) and the SRAM slave.
interface axi_sram_slave_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int ID_WIDTH   = 4,
  parameter int STRB_WIDTH = DATA_WIDTH / 8
);
  logic [ADDR_WIDTH-1:0] AWADDR;
  logic [3:0]            AWLEN;
  logic [2:0]            AWSIZE;
  logic [1:0]            AWBURST;
  logic [ID_WIDTH-1:0]   AWID;
  logic                  AWVALID;
  logic                  AWREADY;

  logic [DATA_WIDTH-1:0] WDATA;
  logic [STRB_WIDTH-1:0] WSTRB;
  logic                  WLAST;
  logic [ID_WIDTH-1:0]   WID;
  logic                  WVALID;
  logic                  WREADY;

  logic [1:0]            BRESP;
  logic [ID_WIDTH-1:0]   BID;
  logic                  BVALID;
  logic                  BREADY;

  logic [ADDR_WIDTH-1:0] ARADDR;
  logic [3:0]            ARLEN;
  logic [2:0]            ARSIZE;
  logic [1:0]            ARBURST;
  logic [ID_WIDTH-1:0]   ARID;
  logic                  ARVALID;
  logic                  ARREADY;

  logic [DATA_WIDTH-1:0] RDATA;
  logic [1:0]            RRESP;
  logic                  RLAST;
  logic [ID_WIDTH-1:0]   RID;
  logic                  RVALID;
  logic                  RREADY;

  modport master (
    output AWADDR, AWLEN, AWSIZE, AWBURST, AWID, AWVALID,
    input  AWREADY,
    output WDATA, WSTRB, WLAST, WID, WVALID,
    input  WREADY,
    input  BRESP, BID, BVALID,
    output BREADY,
    output ARADDR, ARLEN, ARSIZE, ARBURST, ARID, ARVALID,
    input  ARREADY,
    input  RDATA, RRESP, RLAST, RID, RVALID,
    output RREADY
  );

  modport slave (
    input  AWADDR, AWLEN, AWSIZE, AWBURST, AWID, AWVALID,
    output AWREADY,
    input  WDATA, WSTRB, WLAST, WID, WVALID,
    output WREADY,
    output BRESP, BID, BVALID,
    input  BREADY,
    input  ARADDR, ARLEN, ARSIZE, ARBURST, ARID, ARVALID,
    output ARREADY,
    output RDATA, RRESP, RLAST, RID, RVALID,
    input  RREADY
  );
endinterface

// File: rtl/axi_sram_slave.sv
// AXI3 burst slave in front of a single-port synchronous SRAM, one transaction at a time.
// Write beats hit the SRAM combinationally on the W handshake; reads take 2 cycles per beat.
module axi_sram_slave #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int ID_WIDTH   = 4,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int MEM_AW     = 14
) (
  input  logic                  ACLK,
  input  logic                  ARESETn,
  axi_sram_slave_if.slave       s_axi,
  output logic                  sram_en,
  output logic [STRB_WIDTH-1:0] sram_we,
  output logic [MEM_AW-1:0]     sram_addr,
  output logic [DATA_WIDTH-1:0] sram_wdata,
  input  logic [DATA_WIDTH-1:0] sram_rdata,
  output logic                  mem_writing,
  output logic [ADDR_WIDTH-1:0] last_write_address
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WR_DATA = 3'd1,
    S_WR_RESP = 3'd2,
    S_RD_REQ  = 3'd3,
    S_RD_DATA = 3'd4
  } state_e;

  state_e state_q, state_d;

  logic [MEM_AW-1:0]     addr_q, addr_d;
  logic [3:0]            len_q, len_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [ID_WIDTH-1:0]   id_q, id_d;
  logic                  fixed_q, fixed_d;
  logic                  mem_writing_q, mem_writing_d;
  logic [ADDR_WIDTH-1:0] lwa_q, lwa_d;

  logic aw_hs, ar_hs, w_hs, r_hs, rlast;
  logic [MEM_AW-1:0] addr_step;

  // Write wins a same-cycle AW/AR collision; the read waits for the next IDLE.
  assign aw_hs = (state_q == S_IDLE) && s_axi.AWVALID;
  assign ar_hs = (state_q == S_IDLE) && !s_axi.AWVALID && s_axi.ARVALID;
  assign w_hs  = (state_q == S_WR_DATA) && s_axi.WVALID;
  assign r_hs  = (state_q == S_RD_DATA) && s_axi.RREADY;
  assign rlast = (cnt_q == len_q);
  assign addr_step = {{(MEM_AW-1){1'b0}}, !fixed_q};

  logic unused_in;
  assign unused_in = ^{s_axi.AWSIZE, s_axi.ARSIZE, s_axi.WID,
                       s_axi.AWADDR[ADDR_WIDTH-1:MEM_AW+2], s_axi.AWADDR[1:0],
                       s_axi.ARADDR[ADDR_WIDTH-1:MEM_AW+2], s_axi.ARADDR[1:0]};

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (s_axi.AWVALID)      state_d = S_WR_DATA;
        else if (s_axi.ARVALID) state_d = S_RD_REQ;
      end
      // WLAST ends the burst even if it disagrees with AWLEN.
      S_WR_DATA: if (s_axi.WVALID && s_axi.WLAST) state_d = S_WR_RESP;
      S_WR_RESP: if (s_axi.BREADY) state_d = S_IDLE;
      S_RD_REQ:  state_d = S_RD_DATA;
      S_RD_DATA: if (s_axi.RREADY) state_d = rlast ? S_IDLE : S_RD_REQ;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    addr_d        = addr_q;
    len_d         = len_q;
    cnt_d         = cnt_q;
    id_d          = id_q;
    fixed_d       = fixed_q;
    mem_writing_d = mem_writing_q;
    lwa_d         = lwa_q;
    if (aw_hs) begin
      addr_d        = s_axi.AWADDR[MEM_AW+1:2];
      len_d         = s_axi.AWLEN;
      cnt_d         = 4'd0;
      id_d          = s_axi.AWID;
      fixed_d       = (s_axi.AWBURST == 2'b00);
      mem_writing_d = 1'b1;
      lwa_d         = s_axi.AWADDR;
    end else if (ar_hs) begin
      addr_d  = s_axi.ARADDR[MEM_AW+1:2];
      len_d   = s_axi.ARLEN;
      cnt_d   = 4'd0;
      id_d    = s_axi.ARID;
      fixed_d = (s_axi.ARBURST == 2'b00);
    end
    // Word address wraps naturally at 2^MEM_AW.
    if (w_hs || (r_hs && !rlast)) begin
      addr_d = addr_q + addr_step;
      cnt_d  = cnt_q + 4'd1;
    end
    if ((state_q == S_WR_RESP) && s_axi.BREADY) begin
      mem_writing_d = 1'b0;
    end
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      addr_q        <= '0;
      len_q         <= '0;
      cnt_q         <= '0;
      id_q          <= '0;
      fixed_q       <= 1'b0;
      mem_writing_q <= 1'b0;
      lwa_q         <= '0;
    end else begin
      addr_q        <= addr_d;
      len_q         <= len_d;
      cnt_q         <= cnt_d;
      id_q          <= id_d;
      fixed_q       <= fixed_d;
      mem_writing_q <= mem_writing_d;
      lwa_q         <= lwa_d;
    end
  end

  always_comb begin
    s_axi.AWREADY = 1'b0;
    s_axi.ARREADY = 1'b0;
    s_axi.WREADY  = 1'b0;
    s_axi.BVALID  = 1'b0;
    s_axi.BID     = '0;
    s_axi.BRESP   = 2'b00;
    s_axi.RVALID  = 1'b0;
    s_axi.RDATA   = '0;
    s_axi.RID     = '0;
    s_axi.RRESP   = 2'b00;
    s_axi.RLAST   = 1'b0;
    sram_en       = 1'b0;
    sram_we       = '0;
    sram_addr     = '0;
    sram_wdata    = '0;
    case (state_q)
      S_IDLE: begin
        s_axi.AWREADY = 1'b1;
        s_axi.ARREADY = !s_axi.AWVALID;
      end
      S_WR_DATA: begin
        s_axi.WREADY = 1'b1;
        if (s_axi.WVALID) begin
          sram_en    = 1'b1;
          sram_we    = s_axi.WSTRB;
          sram_addr  = addr_q;
          sram_wdata = s_axi.WDATA;
        end
      end
      S_WR_RESP: begin
        s_axi.BVALID = 1'b1;
        s_axi.BID    = id_q;
      end
      S_RD_REQ: begin
        sram_en   = 1'b1;
        sram_addr = addr_q;
      end
      // SRAM stays idle here so its output holds through RREADY backpressure.
      S_RD_DATA: begin
        s_axi.RVALID = 1'b1;
        s_axi.RDATA  = sram_rdata;
        s_axi.RID    = id_q;
        s_axi.RLAST  = rlast;
      end
      default: ;
    endcase
  end

  assign mem_writing        = mem_writing_q;
  assign last_write_address = lwa_q;

endmodule

// File: tb/tb_axi_sram_slave.sv
// Directed bench for axi_sram_slave with a behavioural synchronous SRAM behind it.
module tb_axi_sram_slave;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int IW = 4;
  localparam int SW = DW / 8;
  localparam int MAW = 14;

  logic           ACLK = 1'b0;
  logic           ARESETn;
  logic           sram_en;
  logic [SW-1:0]  sram_we;
  logic [MAW-1:0] sram_addr;
  logic [DW-1:0]  sram_wdata;
  logic [DW-1:0]  sram_rdata;
  logic           mem_writing;
  logic [AW-1:0]  last_write_address;

  axi_sram_slave_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW), .STRB_WIDTH(SW)) axi ();

  axi_sram_slave #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW), .STRB_WIDTH(SW), .MEM_AW(MAW)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn), .s_axi(axi),
    .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
    .sram_rdata(sram_rdata), .mem_writing(mem_writing), .last_write_address(last_write_address)
  );

  always #5 ACLK = ~ACLK;

  logic [DW-1:0] mem [0:(1<<MAW)-1];
  always @(posedge ACLK) begin
    if (sram_en) begin
      for (int b = 0; b < SW; b++)
        if (sram_we[b]) mem[sram_addr][b*8 +: 8] <= sram_wdata[b*8 +: 8];
      if (sram_we == '0) sram_rdata <= mem[sram_addr];
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  int checks = 0;
  int errors = 0;

  logic [DW-1:0]  wr_dat  [0:3];
  logic [SW-1:0]  wr_strb [0:3];
  logic [MAW-1:0] wr_sa   [0:3];
  logic [DW-1:0]  exp_rd  [0:3];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge ACLK);
    #2;
  endtask

  task automatic do_write(input logic [AW-1:0] addr, input logic [3:0] len, input logic [1:0] burst,
                          input logic [IW-1:0] id, input int nbeats, input int bstall);
    axi.AWADDR = addr; axi.AWLEN = len; axi.AWBURST = burst; axi.AWID = id; axi.AWVALID = 1'b1;
    #1;
    chk("awready", axi.AWREADY, 1);
    chk("arready_aw_priority", axi.ARREADY, 0);
    step();
    axi.AWVALID = 1'b0;
    #1;
    chk("wready", axi.WREADY, 1);
    chk("mem_writing_set", mem_writing, 1);
    chk("last_write_address", last_write_address, addr);
    chk("arready_in_wr", axi.ARREADY, 0);
    for (int i = 0; i < nbeats; i++) begin
      axi.WDATA = wr_dat[i]; axi.WSTRB = wr_strb[i]; axi.WID = id;
      axi.WLAST = (i == nbeats - 1); axi.WVALID = 1'b1;
      #1;
      chk("wr_sram_en", sram_en, 1);
      chk("wr_sram_we", sram_we, wr_strb[i]);
      chk("wr_sram_wdata", sram_wdata, wr_dat[i]);
      wr_sa[i] = sram_addr;
      step();
    end
    axi.WVALID = 1'b0; axi.WLAST = 1'b0;
    #1;
    chk("bvalid", axi.BVALID, 1);
    chk("bid", axi.BID, id);
    chk("bresp", axi.BRESP, 0);
    for (int k = 0; k < bstall; k++) begin
      chk("bvalid_hold", axi.BVALID, 1);
      chk("mem_writing_hold", mem_writing, 1);
      chk("arready_in_resp", axi.ARREADY, 0);
      chk("sram_idle_resp", sram_en, 0);
      step();
    end
    axi.BREADY = 1'b1;
    step();
    axi.BREADY = 1'b0;
    #1;
    chk("bvalid_clear", axi.BVALID, 0);
    chk("mem_writing_clear", mem_writing, 0);
    chk("last_write_address_kept", last_write_address, addr);
  endtask

  task automatic do_read(input logic [AW-1:0] addr, input logic [3:0] len, input logic [1:0] burst,
                         input logic [IW-1:0] id, input int nbeats, input int stall_beat, input int stall_n);
    axi.ARADDR = addr; axi.ARLEN = len; axi.ARBURST = burst; axi.ARID = id; axi.ARVALID = 1'b1;
    #1;
    chk("arready", axi.ARREADY, 1);
    step();
    axi.ARVALID = 1'b0;
    for (int i = 0; i < nbeats; i++) begin
      #1;
      chk("rd_req_en", sram_en, 1);
      chk("rd_req_we", sram_we, 0);
      chk("rd_req_rvalid", axi.RVALID, 0);
      step();
      #1;
      chk("rvalid", axi.RVALID, 1);
      chk("rdata", axi.RDATA, exp_rd[i]);
      chk("rlast", axi.RLAST, (i == nbeats - 1));
      chk("rid", axi.RID, id);
      chk("rresp", axi.RRESP, 0);
      chk("rd_data_sram_idle", sram_en, 0);
      if (i == stall_beat) begin
        for (int k = 0; k < stall_n; k++) begin
          step();
          chk("rvalid_stall", axi.RVALID, 1);
          chk("rdata_stall", axi.RDATA, exp_rd[i]);
          chk("rlast_stall", axi.RLAST, (i == nbeats - 1));
          chk("sram_idle_stall", sram_en, 0);
        end
      end
      axi.RREADY = 1'b1;
      step();
      axi.RREADY = 1'b0;
    end
    #1;
    chk("rvalid_done", axi.RVALID, 0);
    chk("awready_idle", axi.AWREADY, 1);
  endtask

  initial begin
    ARESETn = 1'b0;
    sram_rdata = '0;
    axi.AWADDR = '0; axi.AWLEN = '0; axi.AWSIZE = 3'b010; axi.AWBURST = 2'b01; axi.AWID = '0; axi.AWVALID = 1'b0;
    axi.WDATA = '0; axi.WSTRB = '0; axi.WLAST = 1'b0; axi.WID = '0; axi.WVALID = 1'b0;
    axi.BREADY = 1'b0;
    axi.ARADDR = '0; axi.ARLEN = '0; axi.ARSIZE = 3'b010; axi.ARBURST = 2'b01; axi.ARID = '0; axi.ARVALID = 1'b0;
    axi.RREADY = 1'b0;
    repeat (3) step();
    ARESETn = 1'b1;
    #1;
    chk("rst_awready", axi.AWREADY, 1);
    chk("rst_arready", axi.ARREADY, 1);
    chk("rst_wready", axi.WREADY, 0);
    chk("rst_bvalid", axi.BVALID, 0);
    chk("rst_rvalid", axi.RVALID, 0);
    chk("rst_sram_en", sram_en, 0);
    chk("rst_mem_writing", mem_writing, 0);
    chk("rst_lwa", last_write_address, 0);

    // Single write then single read.
    wr_dat[0] = 32'hDEADBEEF; wr_strb[0] = 4'hF;
    do_write(32'h100, 4'd0, 2'b01, 4'd3, 1, 0);
    exp_rd[0] = 32'hDEADBEEF;
    do_read(32'h100, 4'd0, 2'b01, 4'd5, 1, -1, 0);

    // 4-beat INCR write, then read with RREADY held low 3 cycles on beat 2.
    wr_dat[0] = 32'h11; wr_dat[1] = 32'h22; wr_dat[2] = 32'h33; wr_dat[3] = 32'h44;
    for (int i = 0; i < 4; i++) wr_strb[i] = 4'hF;
    do_write(32'h200, 4'd3, 2'b01, 4'd1, 4, 0);
    chk("incr_sa0", wr_sa[0], 14'h080);
    chk("incr_sa3", wr_sa[3], 14'h083);
    exp_rd[0] = 32'h11; exp_rd[1] = 32'h22; exp_rd[2] = 32'h33; exp_rd[3] = 32'h44;
    do_read(32'h200, 4'd3, 2'b01, 4'd2, 4, 1, 3);

    // Partial write over 0x22 with BREADY held low 5 cycles.
    wr_dat[0] = 32'hAAAABBBB; wr_strb[0] = 4'b0011;
    do_write(32'h204, 4'd0, 2'b01, 4'd7, 1, 5);
    exp_rd[0] = 32'h0000BBBB;
    do_read(32'h204, 4'd0, 2'b01, 4'd7, 1, -1, 0);

    // AW and AR raised together: write first, read after the B handshake.
    axi.ARADDR = 32'h300; axi.ARLEN = 4'd0; axi.ARBURST = 2'b01; axi.ARID = 4'd6; axi.ARVALID = 1'b1;
    wr_dat[0] = 32'h5A5A5A5A; wr_strb[0] = 4'hF;
    do_write(32'h300, 4'd0, 2'b01, 4'd9, 1, 2);
    exp_rd[0] = 32'h5A5A5A5A;
    do_read(32'h300, 4'd0, 2'b01, 4'd6, 1, -1, 0);

    // Address wrap at the top of the SRAM.
    wr_dat[0] = 32'hCAFE0001; wr_dat[1] = 32'hCAFE0002;
    do_write(32'h0000FFFC, 4'd1, 2'b01, 4'd2, 2, 0);
    chk("wrap_sa0", wr_sa[0], 14'h3FFF);
    chk("wrap_sa1", wr_sa[1], 14'h0000);
    exp_rd[0] = 32'hCAFE0001; exp_rd[1] = 32'hCAFE0002;
    do_read(32'h0000FFFC, 4'd1, 2'b01, 4'd2, 2, -1, 0);

    // FIXED burst: every beat to the same word.
    wr_dat[0] = 32'h1; wr_dat[1] = 32'h2; wr_dat[2] = 32'h3; wr_dat[3] = 32'h4;
    do_write(32'h400, 4'd3, 2'b00, 4'd4, 4, 0);
    chk("fixed_sa0", wr_sa[0], 14'h100);
    chk("fixed_sa1", wr_sa[1], 14'h100);
    chk("fixed_sa2", wr_sa[2], 14'h100);
    chk("fixed_sa3", wr_sa[3], 14'h100);
    exp_rd[0] = 32'h4;
    do_read(32'h400, 4'd0, 2'b01, 4'd4, 1, -1, 0);

    // AWLEN=0 but WLAST on beat 2: both beats land at successive words.
    wr_dat[0] = 32'h77; wr_dat[1] = 32'h88;
    do_write(32'h500, 4'd0, 2'b01, 4'd8, 2, 0);
    chk("extra_sa1", wr_sa[1], 14'h141);
    exp_rd[0] = 32'h77; exp_rd[1] = 32'h88;
    do_read(32'h500, 4'd1, 2'b01, 4'd8, 2, -1, 0);

    // Reset during RD_DATA of beat 2 abandons the burst.
    axi.ARADDR = 32'h200; axi.ARLEN = 4'd3; axi.ARBURST = 2'b01; axi.ARID = 4'hA; axi.ARVALID = 1'b1;
    step();
    axi.ARVALID = 1'b0;
    step();
    axi.RREADY = 1'b1;
    step();
    axi.RREADY = 1'b0;
    step();
    #1;
    chk("rst_mid_rvalid_before", axi.RVALID, 1);
    chk("rst_mid_rdata_before", axi.RDATA, 32'h0000BBBB);
    ARESETn = 1'b0;
    step();
    #1;
    chk("rst_mid_rvalid", axi.RVALID, 0);
    chk("rst_mid_arready", axi.ARREADY, 1);
    chk("rst_mid_rlast", axi.RLAST, 0);
    chk("rst_mid_sram_en", sram_en, 0);
    ARESETn = 1'b1;
    exp_rd[0] = 32'hDEADBEEF;
    do_read(32'h100, 4'd0, 2'b01, 4'd1, 1, -1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
